// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and data access.
// Data wins ties unless fetch has lost STARVE_MAX grants in a row; stalled waits abort after TIMEOUT cycles.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ready,
  input  logic          dm_rd,
  input  logic          dm_wr,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_ready,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          pipe_stall,
  output logic          bus_err
);

  typedef enum logic [1:0] {IDLE, I_WAIT, D_WAIT} state_t;

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);
  localparam logic [7:0] TMO_LIM    = 8'(TIMEOUT - 1);

  state_t        state_reg, state_next;
  logic          mem_req_reg, mem_req_next;
  logic          mem_we_reg, mem_we_next;
  logic [AW-1:0] mem_addr_reg, mem_addr_next;
  logic [DW-1:0] mem_wdata_reg, mem_wdata_next;
  logic [DW-1:0] if_rdata_reg, if_rdata_next;
  logic [DW-1:0] dm_rdata_reg, dm_rdata_next;
  logic          if_ready_reg, if_ready_next;
  logic          dm_ready_reg, dm_ready_next;
  logic          bus_err_reg, bus_err_next;
  logic [2:0]    starve_reg, starve_next;
  logic [7:0]    tmo_reg, tmo_next;

  logic dm_req;
  logic starved;

  assign dm_req  = dm_rd | dm_wr;
  assign starved = if_req && (starve_reg >= STARVE_LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      if_rdata_reg  <= '0;
      dm_rdata_reg  <= '0;
      if_ready_reg  <= 1'b0;
      dm_ready_reg  <= 1'b0;
      bus_err_reg   <= 1'b0;
      starve_reg    <= '0;
      tmo_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      mem_req_reg   <= mem_req_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      if_rdata_reg  <= if_rdata_next;
      dm_rdata_reg  <= dm_rdata_next;
      if_ready_reg  <= if_ready_next;
      dm_ready_reg  <= dm_ready_next;
      bus_err_reg   <= bus_err_next;
      starve_reg    <= starve_next;
      tmo_reg       <= tmo_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    mem_req_next   = mem_req_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    if_rdata_next  = if_rdata_reg;
    dm_rdata_next  = dm_rdata_reg;
    if_ready_next  = 1'b0;
    dm_ready_next  = 1'b0;
    bus_err_next   = bus_err_reg;
    starve_next    = starve_reg;
    tmo_next       = tmo_reg;

    case (state_reg)
      IDLE: begin
        tmo_next = '0;
        if (dm_req && !starved) begin
          state_next     = D_WAIT;
          mem_req_next   = 1'b1;
          mem_we_next    = dm_wr;
          mem_addr_next  = dm_addr;
          mem_wdata_next = dm_wdata;
          if (if_req && starve_reg != 3'd7)
            starve_next = starve_reg + 3'd1;
        end else if (if_req) begin
          state_next    = I_WAIT;
          mem_req_next  = 1'b1;
          mem_we_next   = 1'b0;
          mem_addr_next = if_addr;
          starve_next   = '0;
        end
      end

      // A requester that dropped out (flush) gets no ready and keeps its old rdata.
      I_WAIT: begin
        if (mem_ack) begin
          state_next   = IDLE;
          mem_req_next = 1'b0;
          tmo_next     = '0;
          if (if_req) begin
            if_ready_next = 1'b1;
            if_rdata_next = mem_rdata;
          end
        end else if (tmo_reg == TMO_LIM) begin
          state_next   = IDLE;
          mem_req_next = 1'b0;
          bus_err_next = 1'b1;
          tmo_next     = '0;
          if (if_req) begin
            if_ready_next = 1'b1;
            if_rdata_next = '0;
          end
        end else begin
          tmo_next = tmo_reg + 8'd1;
        end
      end

      D_WAIT: begin
        if (mem_ack) begin
          state_next   = IDLE;
          mem_req_next = 1'b0;
          tmo_next     = '0;
          if (dm_req) begin
            dm_ready_next = 1'b1;
            if (!mem_we_reg)
              dm_rdata_next = mem_rdata;
          end
        end else if (tmo_reg == TMO_LIM) begin
          state_next   = IDLE;
          mem_req_next = 1'b0;
          bus_err_next = 1'b1;
          tmo_next     = '0;
          if (dm_req) begin
            dm_ready_next = 1'b1;
            dm_rdata_next = '0;
          end
        end else begin
          tmo_next = tmo_reg + 8'd1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign if_rdata   = if_rdata_reg;
  assign if_ready   = if_ready_reg;
  assign dm_rdata   = dm_rdata_reg;
  assign dm_ready   = dm_ready_reg;
  assign mem_req    = mem_req_reg;
  assign mem_we     = mem_we_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_wdata  = mem_wdata_reg;
  assign bus_err    = bus_err_reg;
  assign pipe_stall = (if_req & ~if_ready_reg) | (dm_req & ~dm_ready_reg);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a small memory responder plus a scoreboard
// of expected completions (kind and read data) popped whenever a ready pulse appears.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        dm_rd;
  logic        dm_wr;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        pipe_stall;
  logic        bus_err;

  mem_port_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ready  (if_ready),
    .dm_rd     (dm_rd),
    .dm_wr     (dm_wr),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_ready  (dm_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .pipe_stall(pipe_stall),
    .bus_err   (bus_err)
  );

  typedef struct {
    bit          is_d;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   failed = 0;
  int   total  = 0;

  int   ack_delay  = 3;
  bit   ack_enable = 1;
  bit   ack_force  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h40) return 32'h8C220004;
    return a * 32'd3 + 32'h1000;
  endfunction

  // Memory responder: acks ack_delay cycles after it first sees mem_req.
  initial begin : responder
    bit pending;
    int cnt;
    pending   = 0;
    cnt       = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      mem_ack = 1'b0;
      if (!mem_req) begin
        pending = 0;
      end else begin
        if (!pending) begin
          pending = 1;
          cnt     = 0;
        end else begin
          cnt++;
        end
        if (ack_enable && cnt == ack_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_model(mem_addr);
        end
      end
      if (ack_force) mem_ack = 1'b1;
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input int bound, input bit drop, output int cycles);
    bit   seen;
    exp_t e;
    seen   = 0;
    cycles = 0;
    while (!seen && cycles < bound) begin
      tick();
      cycles++;
      if (if_ready || dm_ready) seen = 1;
    end
    check("ready_seen", 32'(seen), 32'd1);
    if (seen) begin
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("ready_kind", 32'(dm_ready), 32'(e.is_d));
        check("ready_excl", 32'(if_ready & dm_ready), 32'd0);
        check(e.is_d ? "dm_rdata" : "if_rdata", e.is_d ? dm_rdata : if_rdata, e.rdata);
        $display("txn %s rdata=%h after %0d cycles", e.is_d ? "D" : "I",
                 e.is_d ? dm_rdata : if_rdata, cycles);
      end
      if (drop) begin
        if (dm_ready) begin
          dm_rd = 1'b0;
          dm_wr = 1'b0;
        end else begin
          if_req = 1'b0;
        end
      end
    end
  endtask

  initial begin : stim
    int          cyc;
    int          pulses;
    logic [31:0] last_if;
    logic [31:0] last_dm;

    rst = 1'b1; if_req = 1'b1; if_addr = '0;
    dm_rd = 1'b0; dm_wr = 1'b0; dm_addr = '0; dm_wdata = '0;
    ack_force = 1;

    // Reset held two cycles with fetch and ack asserted
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_if_ready", 32'(if_ready), 32'd0);
      check("rst_bus_err", 32'(bus_err), 32'd0);
    end
    rst = 1'b0; if_req = 1'b0; ack_force = 0;
    last_if = '0;
    last_dm = '0;
    tick();

    // Plain fetch
    if_req = 1'b1; if_addr = 32'h40;
    sb.push_back('{is_d: 1'b0, rdata: 32'h8C220004});
    tick();
    check("fetch_mem_req", 32'(mem_req), 32'd1);
    check("fetch_mem_we", 32'(mem_we), 32'd0);
    check("fetch_mem_addr", mem_addr, 32'h40);
    check("fetch_stall", 32'(pipe_stall), 32'd1);
    wait_ready(20, 1, cyc);
    check("fetch_latency", cyc, 32'd4);
    last_if = 32'h8C220004;
    tick();
    check("fetch_ready_pulse", 32'(if_ready), 32'd0);
    check("fetch_mem_req_low", 32'(mem_req), 32'd0);

    // Simultaneous store and fetch: data first, fetch after one bubble
    if_req = 1'b1; if_addr = 32'h80;
    dm_wr = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hCAFEF00D;
    sb.push_back('{is_d: 1'b1, rdata: last_dm});
    sb.push_back('{is_d: 1'b0, rdata: mem_model(32'h80)});
    tick();
    check("prio_mem_we", 32'(mem_we), 32'd1);
    check("prio_mem_addr", mem_addr, 32'h100);
    check("prio_mem_wdata", mem_wdata, 32'hCAFEF00D);
    wait_ready(20, 1, cyc);
    tick();
    check("prio_fetch_req", 32'(mem_req), 32'd1);
    check("prio_fetch_we", 32'(mem_we), 32'd0);
    check("prio_fetch_addr", mem_addr, 32'h80);
    wait_ready(20, 1, cyc);
    last_if = mem_model(32'h80);
    tick();

    // Starvation: loads held continuously, fetch held; 4 loads then one fetch
    ack_delay = 1;
    dm_rd = 1'b1; dm_addr = 32'h200;
    if_req = 1'b1; if_addr = 32'hC0;
    for (int i = 0; i < 4; i++) sb.push_back('{is_d: 1'b1, rdata: mem_model(32'h200)});
    sb.push_back('{is_d: 1'b0, rdata: mem_model(32'hC0)});
    for (int i = 0; i < 5; i++) wait_ready(20, 0, cyc);
    dm_rd = 1'b0; if_req = 1'b0;
    last_dm = mem_model(32'h200);
    last_if = mem_model(32'hC0);
    tick();

    // Starve counter cleared: data wins the tie again
    dm_rd = 1'b1; dm_addr = 32'h204;
    if_req = 1'b1; if_addr = 32'hC4;
    sb.push_back('{is_d: 1'b1, rdata: mem_model(32'h204)});
    sb.push_back('{is_d: 1'b0, rdata: mem_model(32'hC4)});
    tick();
    check("clr_mem_addr", mem_addr, 32'h204);
    wait_ready(20, 1, cyc);
    wait_ready(20, 1, cyc);
    tick();

    // Timeout on a load with no ack
    ack_enable = 0;
    dm_rd = 1'b1; dm_addr = 32'h300;
    sb.push_back('{is_d: 1'b1, rdata: 32'h0});
    tick();
    check("tmo_mem_req", 32'(mem_req), 32'd1);
    wait_ready(300, 1, cyc);
    check("tmo_latency", cyc, 32'd255);
    check("tmo_bus_err", 32'(bus_err), 32'd1);
    check("tmo_mem_req_low", 32'(mem_req), 32'd0);
    ack_enable = 1;
    for (int i = 0; i < 3; i++) tick();
    check("tmo_sticky", 32'(bus_err), 32'd1);

    // Stale ack while idle is ignored
    ack_force = 1;
    tick();
    ack_force = 0;
    tick();
    check("stale_mem_req", 32'(mem_req), 32'd0);
    check("stale_ready", 32'(if_ready | dm_ready), 32'd0);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_clears_err", 32'(bus_err), 32'd0);
    check("rst_clears_if_rdata", if_rdata, 32'd0);

    // Fetch, then a flushed fetch whose result must be discarded
    ack_delay = 3;
    if_req = 1'b1; if_addr = 32'h44;
    sb.push_back('{is_d: 1'b0, rdata: mem_model(32'h44)});
    tick();
    wait_ready(20, 1, cyc);
    last_if = mem_model(32'h44);
    tick();
    if_req = 1'b1; if_addr = 32'h48;
    tick();
    check("flush_mem_req", 32'(mem_req), 32'd1);
    tick();
    if_req = 1'b0;
    #1;
    check("flush_stall", 32'(pipe_stall), 32'd0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (if_ready) pulses++;
    end
    check("flush_no_ready", pulses, 32'd0);
    check("flush_if_rdata", if_rdata, last_if);
    check("flush_mem_req_low", 32'(mem_req), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
